// File: rtl/instr_stream_writer_pkg.sv
// Opcode map, field layout and encoder shared with the control unit's decode.
// Also holds the writer FSM state constants and the request bundle type.
package instr_stream_writer_pkg;

  localparam int IW = 16;

  localparam logic [3:0] OP_LW  = 4'b0000;
  localparam logic [3:0] OP_SW  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_LDC = 4'b0100;
  localparam logic [3:0] OP_BEQ = 4'b0101;

  localparam int OP_LSB  = 12;
  localparam int RS1_LSB = 9;
  localparam int RS2_LSB = 6;
  localparam int RD_LSB  = 3;
  localparam int IMM_LSB = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic [5:0] imm;
  } req_t;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_BEQ;
  endfunction

  function automatic logic [IW-1:0] encode(input req_t r);
    logic [IW-1:0] w;
    w = '0;
    w[OP_LSB +: 4]  = r.op;
    w[RS1_LSB +: 3] = r.rs1;
    w[RS2_LSB +: 3] = r.rs2;
    if (r.op == OP_ADD || r.op == OP_SUB)
      w[RD_LSB +: 3] = r.rd;
    else
      w[IMM_LSB +: 6] = r.imm;
    return w;
  endfunction

endpackage

// File: rtl/instr_stream_writer_if.sv
// Request handshake and instruction-memory write port bundle.
// The host side is master; the writer is slave.
interface instr_stream_writer_if
  import instr_stream_writer_pkg::*;
#(
  parameter int AW = 8
) ();
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [2:0]    req_rs1;
  logic [2:0]    req_rs2;
  logic [2:0]    req_rd;
  logic [5:0]    req_imm;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_rd, req_imm,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_rd, req_imm,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_stream_writer_sync_fifo.sv
// Single-clock FIFO with occupancy count; push and pop may coincide.
// Storage is not reset, only pointers and count.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din;
  end

  assign dout  = mem_q[rptr_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/instr_stream_writer.sv
// Encodes field-level requests into instruction words and streams them
// through a FIFO into instruction memory from a programmed base address.
module instr_stream_writer
  import instr_stream_writer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [AW-1:0]           base_addr,
  input  logic [AW:0]             word_count,
  instr_stream_writer_if.slave    bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err_illegal
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    state_q, state_d;
  logic [AW:0]   cnt_q, cnt_eff;
  logic [AW:0]   acc_q, acc_d;
  logic [AW:0]   wr_q, wr_d;
  logic [AW-1:0] ptr_q, addr_q;
  logic [IW-1:0] wdata_q, enc, head;
  logic          ready_q, ready_d;
  logic          we_q, err_q;
  logic          accept, legal, push, pop;
  logic          full, empty;
  logic [CW-1:0] occ, occ_d;
  req_t          req;

  assign req    = '{op:  bus.req_op,  rs1: bus.req_rs1,
                    rs2: bus.req_rs2, rd:  bus.req_rd,
                    imm: bus.req_imm};
  assign accept = bus.req_valid & ready_q;
  assign legal  = op_legal(req.op);
  assign push   = accept & legal & ~full;
  assign pop    = (state_q == S_LOAD) & ~empty;
  assign enc    = encode(req);

  sync_fifo #(.WIDTH(IW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (enc),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        acc_d   = '0;
        wr_d    = '0;
        state_d = (word_count == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (push) acc_d = acc_q + 1'b1;
        if (pop)  wr_d  = wr_q + 1'b1;
        if (wr_q == cnt_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is registered, so it is computed from next-cycle occupancy/counts.
  assign cnt_eff = (state_q == S_IDLE) ? word_count : cnt_q;
  assign occ_d   = occ + CW'(push) - CW'(pop);
  assign ready_d = (state_d == S_LOAD) &&
                   (occ_d != CW'(DEPTH)) &&
                   (acc_d < cnt_eff);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      wr_q    <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      we_q    <= pop;
      err_q   <= accept & ~legal;
      if (state_q == S_IDLE && start) begin
        cnt_q <= word_count;
        ptr_q <= base_addr;
      end
      if (pop) begin
        addr_q  <= ptr_q;
        wdata_q <= head;
        ptr_q   <= ptr_q + 1'b1;
      end
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign err_illegal    = err_q;

endmodule

// File: doc/instr_stream_writer.md
# instr_stream_writer

Instruction-word encoder and writer: the producer-side counterpart of the control unit's opcode decoder. Accepts field-level instruction requests on a valid/ready handshake and encodes them into 16-bit instruction words using the processor's opcode map. Buffers the words in a small FIFO and writes them sequentially into instruction memory starting at a programmed base address. Sits between the test/boot host and the instruction memory write port.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `AW`, default 8: instruction-memory address width.
- `clk` in 1: sole clock; rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a load session; sampled only in IDLE.
- `base_addr` in AW: first write address; sampled with `start`.
- `word_count` in AW+1: number of legal words to write (0..2^AW); sampled with `start`.
- `req_valid` in 1: request present.
- `req_ready` out 1: block accepts a request this cycle.
- `req_op` in 4: opcode (0000 LW, 0001 SW, 0010 ADD, 0011 SUB, 0100 LDC, 0101 BEQ).
- `req_rs1`, `req_rs2`, `req_rd` in 3 each: register fields.
- `req_imm` in 6: offset/constant, two's complement.
- `imem_we` out 1: write strobe, one word per cycle.
- `imem_addr` out AW: write address.
- `imem_wdata` out 16: encoded word.
- `busy` out 1: high in LOAD and DONE.
- `done` out 1: one-cycle pulse at session end.
- `err_illegal` out 1: one-cycle pulse when an illegal opcode is accepted.

## Operation
- Encoding: ADD/SUB → {op, rs1, rs2, rd, 3'b000}; LW/SW/LDC/BEQ → {op, rs1, rs2, imm}. `req_rd` ignored for I-type, `req_imm` ignored for R-type.
- Illegal opcode (0110–1111): handshake completes, nothing enqueued, `err_illegal` pulses the following cycle, not counted toward `word_count`.
- States:
  - IDLE: `req_ready`=0. `start` → latch base/count, clear counters, go LOAD. If `word_count`=0, go DONE instead.
  - LOAD: `req_ready` = FIFO not full AND accepted_legal < count. FIFO head popped and written each cycle it is non-empty. When written == count → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `start` outside IDLE is ignored.
- `imem_addr` increments by 1 per write and wraps modulo 2^AW (e.g. base 0xFE, 4 words → FE, FF, 00, 01).
- Simultaneous push and pop on a non-empty FIFO allowed; occupancy unchanged.
- Reset values: `req_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `busy`=0, `done`=0, `err_illegal`=0, FIFO empty, state IDLE.
- Reset mid-session: discards all buffered words; no further `imem_we`; no `done` pulse.

## Timing
- Handshake completes on an edge where `req_valid` && `req_ready`. `req_*` must be stable while `req_valid` is high and not accepted.
- `req_ready` is a registered function of state, FIFO occupancy and counters; it does not depend combinationally on `req_valid`.
- Latency: request accepted at edge k → `imem_we`/`imem_addr`/`imem_wdata` valid in the cycle following edge k+1. All `imem_*` outputs registered; `imem_we` low in cycles with no write.
- Throughput: one word per cycle sustained with `req_valid` held high.
- `done` is asserted in the cycle after the final `imem_we` cycle; `busy` falls together with `done`.
- `err_illegal` asserted in the cycle after the accepting edge.

## Structure
- Shared package holds opcode constants (OP_LW … OP_BEQ), field bit positions, and the instruction-word width (16). The same constants are used by the control unit's decode.
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count). Encoder logic and FSM stay in the top.

## Test plan
- Session base=0x10, count=3; send ADD r1,r2→r3, LW r4,r5,imm=-2, BEQ r0,r0,imm=5 → writes 0x10:0x2298, 0x11:0x097E, 0x12:0x5005; `done` one cycle after the last write.
- Base 0xFE, count 4, back-to-back ADDs → addresses FE, FF, 00, 01 on consecutive cycles; `imem_we` continuous.
- Opcode 0111 mid-stream with count 2 → `err_illegal` pulse, no write, session still writes exactly 2 legal words.
- `word_count`=0 → `done` in the cycle after `start`, zero `imem_we`, `req_ready` never high.
- Fill the FIFO by holding the write side busy with DEPTH+2 requests → `req_ready` drops only while full; order preserved, no loss or duplication.
- Assert `reset` with 3 words buffered → all outputs at reset values next cycle; no further writes; a new `start` works normally.
